// File: rtl/dac_seq_pkg.sv
// Shared encodings and widths for the R2R DAC sample sequencer.
package dac_seq_pkg;

  localparam int CODE_W = 8;
  localparam int RATE_W = 8;

  typedef enum logic [1:0] {
    MODE_FIFO = 2'd0,
    MODE_SAW  = 2'd1,
    MODE_TRI  = 2'd2,
    MODE_HOLD = 2'd3
  } mode_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PLAY = 1'b1
  } state_t;

endpackage

// File: rtl/dac_sample_fifo.sv
// Synchronous show-ahead sample FIFO; flush clears pointers and level,
// overriding any same-cycle push or pop.
module dac_sample_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             head,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = 1;
  localparam logic [AW:0]   LVL_ONE  = 1;
  localparam logic [AW:0]   FULL_LVL = DEPTH[AW:0];

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (cnt == FULL_LVL);
  assign empty   = (cnt == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem[rd_ptr];
  assign level   = cnt;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + LVL_ONE;
        2'b01:   cnt <= cnt - LVL_ONE;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/r2r_dac_seq_ctrl.sv
// Sample sequencer for the 8-bit R2R ladder DAC: FIFO playback or internal
// saw/triangle generation paced by a rate divider. Optional: DAC_URUN_CNT_EN.
module r2r_dac_seq_ctrl
  import dac_seq_pkg::*;
#(
  parameter int                DEPTH      = 16,
  parameter int                STEP       = 1,
  parameter logic [CODE_W-1:0] RESET_CODE = 8'h80
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_valid,
  input  logic [CODE_W-1:0]      wr_data,
  output logic                   wr_ready,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   flush,
  input  logic [1:0]             mode,
  input  logic [RATE_W-1:0]      rate,
  output logic [CODE_W-1:0]      dac_code,
  output logic                   sample_stb,
  output logic                   busy,
  output logic                   underrun,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic [7:0]             urun_cnt
);

  localparam logic [CODE_W-1:0] STEP_C  = CODE_W'(STEP);
  localparam logic [CODE_W-1:0] TRI_TOP = CODE_W'(255 - STEP);

  state_t              state, state_nxt;
  mode_t               mode_q;
  logic [RATE_W-1:0]   rate_q;
  logic [RATE_W-1:0]   div_cnt;
  logic [CODE_W-1:0]   code_q;
  logic                stb_q;
  logic                urun_q;
  logic                tri_up;
  logic                start_acc;
  logic                tick;
  logic                pop;
  logic                fifo_full;
  logic                fifo_empty;
  logic [CODE_W-1:0]   head;

  dac_sample_fifo #(.DEPTH(DEPTH), .W(CODE_W)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (wr_valid),
    .pop   (pop),
    .flush (flush),
    .din   (wr_data),
    .head  (head),
    .level (fifo_level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // stop has priority over start; start during PLAY is ignored
  always_comb begin
    state_nxt = state;
    start_acc = 1'b0;
    case (state)
      ST_IDLE: if (start && !stop) begin
        start_acc = 1'b1;
        state_nxt = ST_PLAY;
      end
      ST_PLAY: if (stop) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign tick = (state == ST_PLAY) && !stop && (div_cnt == '0);
  // a flushed tick is consumed without updating the code
  assign pop  = tick && (mode_q == MODE_FIFO) && !fifo_empty && !flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q  <= MODE_FIFO;
      rate_q  <= '0;
      div_cnt <= '0;
      code_q  <= RESET_CODE;
      stb_q   <= 1'b0;
      urun_q  <= 1'b0;
      tri_up  <= 1'b1;
    end else begin
      stb_q <= 1'b0;
      if (start_acc) begin
        mode_q  <= mode_t'(mode);
        rate_q  <= rate;
        div_cnt <= rate;
        urun_q  <= 1'b0;
        tri_up  <= 1'b1;
      end else if ((state == ST_PLAY) && !stop) begin
        div_cnt <= (div_cnt == '0) ? rate_q : div_cnt - 8'd1;
      end
      if (tick) begin
        case (mode_q)
          MODE_FIFO: begin
            if (fifo_empty) begin
              urun_q <= 1'b1;
            end else if (!flush) begin
              code_q <= head;
              stb_q  <= 1'b1;
            end
          end
          MODE_SAW: begin
            code_q <= code_q + STEP_C;
            stb_q  <= 1'b1;
          end
          MODE_TRI: begin
            stb_q <= 1'b1;
            if (tri_up) begin
              if (code_q >= TRI_TOP) begin
                code_q <= '1;
                tri_up <= 1'b0;
              end else begin
                code_q <= code_q + STEP_C;
              end
            end else begin
              if (code_q <= STEP_C) begin
                code_q <= '0;
                tri_up <= 1'b1;
              end else begin
                code_q <= code_q - STEP_C;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef DAC_URUN_CNT_EN
  logic [7:0] urun_cnt_q;

  always_ff @(posedge clk) begin
    if (rst || start_acc)
      urun_cnt_q <= '0;
    else if (tick && (mode_q == MODE_FIFO) && fifo_empty && (urun_cnt_q != '1))
      urun_cnt_q <= urun_cnt_q + 8'd1;
  end

  assign urun_cnt = urun_cnt_q;
`else
  assign urun_cnt = '0;
`endif

  assign wr_ready   = !fifo_full;
  assign dac_code   = code_q;
  assign sample_stb = stb_q;
  assign busy       = (state == ST_PLAY);
  assign underrun   = urun_q;

endmodule
